// File: rtl/morse_pkg.sv
// Shared types and letter tables for the Morse message sequencer.
// A pattern is left-aligned with the first element in bit 3 (1 = dash).
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ON   = 3'd2,
    GAP  = 3'd3,
    LGAP = 3'd4
  } state_t;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  // Returns {pattern[3:0], size[2:0]}.
  function automatic logic [6:0] morse_lut(input logic [2:0] code);
    logic [6:0] res;
    case (code)
      LTR_A:   res = {4'b0100, 3'd2};
      LTR_B:   res = {4'b1000, 3'd4};
      LTR_C:   res = {4'b1010, 3'd4};
      LTR_D:   res = {4'b1000, 3'd3};
      LTR_E:   res = {4'b0000, 3'd1};
      LTR_F:   res = {4'b0010, 3'd4};
      LTR_G:   res = {4'b1100, 3'd3};
      default: res = {4'b0000, 3'd4};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// Small letter FIFO with synchronous flush; read data is the current head entry.
module morse_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/morse_msg_sequencer.sv
// Plays queued letters A..H as Morse code on one LED using a unit-time prescaler.
// FSM, prescaler and unit counter live here; letters are buffered in morse_fifo.
module morse_msg_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int DEPTH    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Abort,
  input  logic       In_Valid,
  input  logic [2:0] In_Letter,
  output logic       In_Ready,
  output logic       LEDR,
  output logic       Busy,
  output logic       Done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] TICK_PRE  = PW'(TICK_DIV - 2);

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [1:0]    unit_reg, unit_next;
  logic [2:0]    remain_reg, remain_next;
  logic [3:0]    pat_reg, pat_next;
  logic          led_reg, led_next;
  logic          done_reg, done_next;

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [2:0] fifo_rdata;
  logic       tick, elem_last;

  assign fifo_push = In_Valid && !fifo_full && !Abort;
  assign fifo_pop  = (state_reg == LOAD) && !Abort;

  morse_fifo #(.DEPTH(DEPTH), .W(3)) u_fifo (
    .clk   (Clk),
    .rst_n (Reset),
    .flush (Abort),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (In_Letter),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tick      = (presc_reg == TICK_LAST);
  assign elem_last = pat_reg[3] ? (unit_reg == 2'd2) : (unit_reg == 2'd0);

  always_comb begin
    state_next  = state_reg;
    presc_next  = tick ? '0 : presc_reg + 1'b1;
    unit_next   = tick ? unit_reg + 1'b1 : unit_reg;
    remain_next = remain_reg;
    pat_next    = pat_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        presc_next = '0;
        unit_next  = '0;
        if (!fifo_empty) state_next = LOAD;
      end
      LOAD: begin
        presc_next              = '0;
        unit_next               = '0;
        {pat_next, remain_next} = morse_lut(fifo_rdata);
        state_next              = ON;
      end
      ON: begin
        if (tick && elem_last) begin
          remain_next = remain_reg - 1'b1;
          pat_next    = {pat_reg[2:0], 1'b0};
          unit_next   = '0;
          state_next  = (remain_reg != 3'd1) ? GAP : LGAP;
        end
      end
      GAP: begin
        if (tick) begin
          unit_next  = '0;
          state_next = ON;
        end
      end
      LGAP: begin
        // The LOAD cycle is the final low cycle of the letter gap, so a
        // waiting letter leaves LGAP one cycle early to keep the gap exact.
        if (unit_reg == 2'd2 && presc_reg == TICK_PRE && !fifo_empty) begin
          state_next = LOAD;
        end else if (tick && unit_reg == 2'd2) begin
          unit_next = '0;
          if (!fifo_empty) begin
            state_next = LOAD;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (Abort) begin
      state_next = IDLE;
      presc_next = '0;
      unit_next  = '0;
      done_next  = 1'b0;
    end
    led_next = (state_next == ON);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= IDLE;
      presc_reg  <= '0;
      unit_reg   <= '0;
      remain_reg <= '0;
      pat_reg    <= '0;
      led_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      unit_reg   <= unit_next;
      remain_reg <= remain_next;
      pat_reg    <= pat_next;
      led_reg    <= led_next;
      done_reg   <= done_next;
    end
  end

  assign In_Ready = !fifo_full;
  assign LEDR     = led_reg;
  assign Busy     = (state_reg != IDLE);
  assign Done     = done_reg;

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Bench for morse_msg_sequencer: expected LED waveforms are built from the
// dot/dash strings of each letter and compared cycle by cycle.
module tb_morse_msg_sequencer;

  localparam int TD = 4;
  localparam int DP = 4;

  logic       Clk = 1'b0;
  logic       Reset, Abort, In_Valid;
  logic [2:0] In_Letter;
  logic       In_Ready, LEDR, Busy, Done;

  morse_msg_sequencer #(.TICK_DIV(TD), .DEPTH(DP)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Abort     (Abort),
    .In_Valid  (In_Valid),
    .In_Letter (In_Letter),
    .In_Ready  (In_Ready),
    .LEDR      (LEDR),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  bit led_q[$];
  bit done_q[$];
  always @(negedge Clk) begin
    led_q.push_back(LEDR);
    done_q.push_back(Done);
  end

  int checks = 0;
  int errors = 0;
  int msg_q[$];
  bit exp_q[$];

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic string mstr(input int l);
    case (l)
      0: return ".-";
      1: return "-...";
      2: return "-.-.";
      3: return "-..";
      4: return ".";
      5: return "..-.";
      6: return "--.";
      default: return "....";
    endcase
  endfunction

  task automatic build_exp();
    exp_q.delete();
    foreach (msg_q[j]) begin
      string m = mstr(msg_q[j]);
      for (int k = 0; k < m.len(); k++) begin
        int d = (m.getc(k) == 8'h2D) ? 3 * TD : TD;
        repeat (d) exp_q.push_back(1'b1);
        if (k < m.len() - 1) repeat (TD) exp_q.push_back(1'b0);
      end
      repeat (3 * TD) exp_q.push_back(1'b0);
    end
  endtask

  function automatic int count_from(input int s, input bit use_done);
    int n = 0;
    for (int k = s; k < led_q.size(); k++)
      n += use_done ? int'(done_q[k]) : int'(led_q[k]);
    return n;
  endfunction

  task automatic push(input int code);
    int t = 0;
    while (In_Ready !== 1'b1 && t < 500) begin
      @(negedge Clk);
      t++;
    end
    chk("push_wait_timeout", int'(t < 500), 1);
    In_Valid  = 1'b1;
    In_Letter = 3'(code);
    @(negedge Clk);
    In_Valid  = 1'b0;
  endtask

  task automatic wait_led(input string tag);
    int t = 0;
    while (LEDR !== 1'b1 && t < 100) begin
      @(negedge Clk);
      t++;
    end
    chk(tag, int'(t < 100), 1);
  endtask

  task automatic run_check(input string tag, input int s);
    int t = 0;
    int i, len;
    int bad = 0;
    while (Done !== 1'b1 && t < 4000) begin
      @(negedge Clk);
      t++;
    end
    chk({tag, "_done_timeout"}, int'(t < 4000), 1);
    repeat (3) @(negedge Clk);
    build_exp();
    len = exp_q.size();
    i = s;
    while (i < led_q.size() && led_q[i] == 1'b0) i++;
    if (i + len >= led_q.size()) bad = len;
    else for (int k = 0; k < len; k++)
      if (led_q[i+k] != exp_q[k] || done_q[i+k]) bad++;
    chk({tag, "_wave_bad_cycles"}, bad, 0);
    chk({tag, "_done_at_end"}, (i + len < led_q.size()) ? int'(done_q[i+len]) : 0, 1);
    chk({tag, "_done_count"}, count_from(s, 1'b1), 1);
    chk({tag, "_busy_after"}, int'(Busy), 0);
    $display("msg %s letters=%0d cycles=%0d bad=%0d", tag, msg_q.size(), len, bad);
  endtask

  initial begin
    int s;
    Reset = 1'b0; Abort = 1'b0; In_Valid = 1'b0; In_Letter = 3'd0;
    #1;
    chk("rst_led", int'(LEDR), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_ready", int'(In_Ready), 1);
    chk("rst_done", int'(Done), 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;

    s = led_q.size();
    repeat (20) @(negedge Clk);
    chk("idle_done", count_from(s, 1'b1), 0);
    chk("idle_led", count_from(s, 1'b0), 0);
    chk("idle_busy", int'(Busy), 0);
    $display("step idle cycles=20");

    // Single E, including first-letter latency from IDLE.
    msg_q = '{4};
    s = led_q.size();
    push(4);
    chk("lat_c1", int'(LEDR), 0);
    @(negedge Clk);
    chk("lat_c2", int'(LEDR), 0);
    @(negedge Clk);
    chk("lat_c3", int'(LEDR), 1);
    run_check("E", s);

    msg_q = '{0};
    s = led_q.size();
    push(0);
    run_check("A", s);

    // Fill the FIFO while A plays.
    msg_q = '{0, 1, 2, 3, 4};
    s = led_q.size();
    push(0);
    wait_led("full_led_timeout");
    for (int k = 1; k < 5; k++) push(k);
    chk("full_ready0", int'(In_Ready), 0);
    repeat (4) @(negedge Clk);
    chk("full_ready_hold", int'(In_Ready), 0);
    run_check("ABCDE", s);

    for (int r = 0; r < 6; r++) begin
      int n = int'($urandom_range(1, 6));
      msg_q.delete();
      for (int k = 0; k < n; k++) msg_q.push_back(int'($urandom_range(0, 7)));
      s = led_q.size();
      foreach (msg_q[k]) push(msg_q[k]);
      run_check($sformatf("rand%0d", r), s);
    end

    // Abort in the middle of C's first dash, with a competing push.
    push(2);
    wait_led("abort_led_timeout");
    repeat (5) @(negedge Clk);
    s = led_q.size();
    Abort = 1'b1; In_Valid = 1'b1; In_Letter = 3'd0;
    @(negedge Clk);
    Abort = 1'b0; In_Valid = 1'b0;
    chk("abort_led", int'(LEDR), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_done", int'(Done), 0);
    chk("abort_ready", int'(In_Ready), 1);
    repeat (20) @(negedge Clk);
    chk("abort_still_idle", int'(Busy), 0);
    chk("abort_no_done", count_from(s, 1'b1), 0);
    chk("abort_led_quiet", count_from(s + 2, 1'b0), 0);
    $display("step abort done");
    msg_q = '{7};
    s = led_q.size();
    push(7);
    run_check("H_after_abort", s);

    // Reset during B with D queued.
    push(1);
    push(3);
    wait_led("reset_led_timeout");
    repeat (6) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("mid_rst_led", int'(LEDR), 0);
    chk("mid_rst_busy", int'(Busy), 0);
    chk("mid_rst_ready", int'(In_Ready), 1);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    s = led_q.size();
    repeat (20) @(negedge Clk);
    chk("post_rst_busy", int'(Busy), 0);
    chk("post_rst_ready", int'(In_Ready), 1);
    chk("post_rst_led", count_from(s, 1'b0), 0);
    chk("post_rst_done", count_from(s, 1'b1), 0);
    $display("step reset done");
    msg_q = '{5};
    s = led_q.size();
    push(5);
    run_check("F_after_reset", s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
